// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer and the downstream sequence-detector stage.
package bit_serializer_pkg;

  // Shifter state encoding; the detector stage reuses these constants.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Bit-counter width for a word of w bits; clamped so a degenerate w still yields one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry valid/ready holding register feeding the shifter.
module bit_serializer_hold
  import bit_serializer_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         take,
  output logic [W-1:0] hold_data,
  output logic         hold_full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;
  logic         accept;

  // in_ready comes straight from the full flag so upstream sees no combinational path.
  assign in_ready  = !full_q;
  assign accept    = in_valid & in_ready;
  assign hold_data = data_q;
  assign hold_full = full_q;

  // Next-state: a take empties the entry, a same-edge accept refills it.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter producing the 1-bit/cycle x stream for the detector.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         en,
  output logic         x,
  output logic         x_valid,
  output logic         frame_start,
  output logic         busy
);

  localparam int unsigned          CNT_W = cnt_w(W);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(W - 1);

  logic [W-1:0]     hold_data;
  logic             hold_full;
  logic             take;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sh_q, sh_d;
  logic             x_q, x_d;
  logic             fs_q, fs_d;

  bit_serializer_hold #(
    .W (W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (take),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  assign x           = x_q;
  assign x_valid     = (state_q == S_SHIFT);
  assign frame_start = fs_q;
  assign busy        = x_valid | hold_full;

  // Next-state for shifter, counter and output bit; en=0 leaves everything as is.
  // The shifter keeps only the bits not yet on x, so the head bit is always the next one out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    x_d     = x_q;
    fs_d    = fs_q;
    take    = 1'b0;
    if (en) begin
      if ((state_q == S_SHIFT) && (cnt_q != LAST)) begin
        x_d   = MSB_FIRST ? sh_q[W-1] : sh_q[0];
        sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
        cnt_d = cnt_q + CNT_W'(1);
        fs_d  = 1'b0;
      end else if (hold_full) begin
        take    = 1'b1;
        x_d     = MSB_FIRST ? hold_data[W-1] : hold_data[0];
        sh_d    = MSB_FIRST ? (hold_data << 1) : (hold_data >> 1);
        cnt_d   = '0;
        fs_d    = 1'b1;
        state_d = S_SHIFT;
      end else begin
        x_d     = IDLE_BIT;
        cnt_d   = '0;
        fs_d    = 1'b0;
        state_d = S_IDLE;
      end
    end
  end

  // Shifter and output registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      x_q     <= IDLE_BIT;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
      fs_q    <= fs_d;
    end
  end

endmodule
